irq_vec_ctrl: RTL and testbench

- Parametrised vectored interrupt controller for the pipelined RISC-V core.
- Replaces the single-source external-interrupt handler.
- Accepts NUM_SRC asynchronous interrupt lines, synchronises them, and tracks each line's pending state (edge- or level-triggered per source).
- Arbitrates among pending, unmasked sources and drives a request/take/return handshake with the pipeline hazard logic, supplying a per-source handler address.

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_sync_edge.sv | 28 ++
 rtl/irq_vec_ctrl.sv | 121 ++++++++++++
 tb/tb_irq_vec_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: synchroniser chain plus rising-edge detector on the last stage.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic sync_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_vec_ctrl.sv
// Vectored interrupt controller: per-source sync/pending, arbitration, req/take/ret handshake.
// Define IRQ_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module irq_vec_ctrl import irq_pkg::*; #(
    parameter int                 NUM_SRC     = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = {NUM_SRC{1'b1}},
    parameter logic [31:0]        VEC_BASE    = VEC_BASE_DEF,
    parameter logic [31:0]        VEC_STRIDE  = VEC_STRIDE_DEF,
    localparam int                IDW         = id_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               irq_take_i,
    input  logic               irq_ret_i,
    output logic               irq_req_o,
    output logic [31:0]        irq_addr_o,
    output logic [IDW-1:0]     irq_id_o,
    output logic               in_service_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] mask_o
);

    logic [NUM_SRC-1:0] sync_vec, edge_vec;
    logic [NUM_SRC-1:0] pend_q, pend_d, clr_vec;
    logic [NUM_SRC-1:0] mask_q, act;
    logic [IDW-1:0]     id_q, id_d, win;
    irq_state_e         state_q, state_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst   (rst),
            .irq_i (irq_i[g]),
            .sync_o(sync_vec[g]),
            .edge_o(edge_vec[g])
        );
    end

    // Level sources follow the synchronised line directly; edge sources are latched.
    assign pending_o = (pend_q & EDGE_MASK) | (sync_vec & ~EDGE_MASK);
    assign act       = pending_o & mask_q;

`ifdef IRQ_RR_EN
    logic [IDW-1:0] last_q;

    always_comb begin
        logic [IDW-1:0] idx;
        win = '0;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = IDW'((int'(last_q) + 1 + i) % NUM_SRC);
            if (act[idx]) win = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                   last_q <= IDW'(NUM_SRC - 1);
        else if (state_q == REQ && irq_take_i)     last_q <= id_q;
    end
`else
    always_comb begin
        win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) win = IDW'(i);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clr_vec = '0;
        case (state_q)
            IDLE: begin
                if (|act) begin
                    state_d = REQ;
                    id_d    = win;
                end
            end
            REQ: begin
                if (irq_take_i) begin
                    state_d = SERVICE;
                    clr_vec = (NUM_SRC'(1) << id_q) & EDGE_MASK;
                end else if (!act[id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (irq_ret_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge in the same cycle as its take-clear keeps the bit set.
    assign pend_d = ((pend_q & ~clr_vec) | edge_vec) & EDGE_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    assign irq_req_o    = (state_q == REQ);
    assign in_service_o = (state_q == SERVICE);
    assign irq_id_o     = id_q;
    assign irq_addr_o   = VEC_BASE + 32'(id_q) * VEC_STRIDE;
    assign mask_o       = mask_q;

endmodule

// File: tb/tb_irq_vec_ctrl.sv
// Scoreboard bench: instance A uses edge sources, instance B level sources.
module tb_irq_vec_ctrl;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [3:0]  a_irq, a_mwd, a_pend, a_mask;
    logic        a_mwe, a_take, a_ret, a_req, a_svc;
    logic [31:0] a_addr;
    logic [1:0]  a_id;

    logic [3:0]  b_irq, b_mwd, b_pend, b_mask;
    logic        b_mwe, b_take, b_ret, b_req, b_svc;
    logic [31:0] b_addr;
    logic [1:0]  b_id;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;
    logic a_prev = 1'b0, b_prev = 1'b0;
    int   checks = 0, failures = 0;
    int   n;

    always #5 clk = ~clk;

    irq_vec_ctrl #(.NUM_SRC(4), .SYNC_STAGES(2), .EDGE_MASK(4'b1111)) u_a (
        .clk(clk), .rst(rst), .irq_i(a_irq), .mask_we(a_mwe), .mask_wdata(a_mwd),
        .irq_take_i(a_take), .irq_ret_i(a_ret), .irq_req_o(a_req), .irq_addr_o(a_addr),
        .irq_id_o(a_id), .in_service_o(a_svc), .pending_o(a_pend), .mask_o(a_mask)
    );

    irq_vec_ctrl #(.NUM_SRC(4), .SYNC_STAGES(2), .EDGE_MASK(4'b0000)) u_b (
        .clk(clk), .rst(rst), .irq_i(b_irq), .mask_we(b_mwe), .mask_wdata(b_mwd),
        .irq_take_i(b_take), .irq_ret_i(b_ret), .irq_req_o(b_req), .irq_addr_o(b_addr),
        .irq_id_o(b_id), .in_service_o(b_svc), .pending_o(b_pend), .mask_o(b_mask)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [1:0] id, input logic [31:0] addr);
        exp_t e;
        e.id = id; e.addr = addr;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] id, input logic [31:0] addr);
        exp_t e;
        e.id = id; e.addr = addr;
        exp_b.push_back(e);
    endtask

    task automatic wait_req(input bit sel, output int cnt);
        cnt = 0;
        while (((sel ? b_req : a_req) !== 1'b1) && cnt < 40) begin
            tick;
            cnt++;
        end
        check(sel ? "b_req_wait" : "a_req_wait", sel ? b_req : a_req, 1);
    endtask

    // Monitors: each rising request is matched against the next expected grant.
    always @(negedge clk) begin
        if (rst) begin
            a_prev = 1'b0;
        end else begin
            if (a_req && !a_prev) begin
                if (exp_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_unexpected_req id=%0d expected=none", a_id);
                end else begin
                    ea = exp_a.pop_front();
                    check("a_id", a_id, ea.id);
                    check("a_addr", a_addr, ea.addr);
                end
            end
            a_prev = a_req;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_prev = 1'b0;
        end else begin
            if (b_req && !b_prev) begin
                if (exp_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected_req id=%0d expected=none", b_id);
                end else begin
                    eb = exp_b.pop_front();
                    check("b_id", b_id, eb.id);
                    check("b_addr", b_addr, eb.addr);
                end
            end
            b_prev = b_req;
        end
    end

    initial begin
        rst = 1'b1;
        a_irq = '0; a_mwd = '0; a_mwe = 0; a_take = 0; a_ret = 0;
        b_irq = '0; b_mwd = '0; b_mwe = 0; b_take = 0; b_ret = 0;
        repeat (3) tick;
        check("rst_req", a_req, 0);
        check("rst_id", a_id, 0);
        check("rst_addr", a_addr, 32'h100);
        check("rst_svc", a_svc, 0);
        check("rst_pend", a_pend, 0);
        check("rst_mask", a_mask, 0);
        rst = 1'b0;

        a_mwe = 1; a_mwd = 4'hF; b_mwe = 1; b_mwd = 4'hF;
        tick;
        a_mwe = 0; b_mwe = 0;
        check("mask_wr", a_mask, 4'hF);

        // single edge on source 2
        push_a(2, 32'h120);
        a_irq = 4'b0100; tick; a_irq = '0;
        wait_req(0, n);
        check("latency", n + 1, 4);
        check("pend_2", a_pend, 4'b0100);
        a_take = 1; tick; a_take = 0;
        check("take_svc", a_svc, 1);
        check("take_req", a_req, 0);
        check("take_pend", a_pend, 4'b0000);
        a_ret = 1; tick; a_ret = 0;
        check("ret_svc", a_svc, 0);

        // simultaneous sources 1 and 3
`ifdef IRQ_RR_EN
        push_a(3, 32'h130); push_a(1, 32'h110);
`else
        push_a(1, 32'h110); push_a(3, 32'h130);
`endif
        a_irq = 4'b1010; tick; a_irq = '0;
        wait_req(0, n);
        check("pend_13", a_pend, 4'b1010);
        a_take = 1; tick; a_take = 0;
`ifdef IRQ_RR_EN
        check("pend_after1", a_pend, 4'b0010);
`else
        check("pend_after1", a_pend, 4'b1000);
`endif
        a_take = 1; tick; a_take = 0;
        check("take_in_svc", a_svc, 1);
        a_ret = 1; tick; a_ret = 0;
        wait_req(0, n);
        a_take = 1; tick; a_take = 0;
        check("pend_after2", a_pend, 4'b0000);
        a_ret = 1; tick; a_ret = 0;

        // edge on source 0 coincides with take of source 0
        push_a(0, 32'h100);
        a_irq = 4'b0001; tick; a_irq = '0;
        wait_req(0, n);
        a_irq = 4'b0001; tick;
        a_irq = '0; tick;
        a_take = 1; tick; a_take = 0;
        check("setwin_svc", a_svc, 1);
        check("setwin_pend", a_pend, 4'b0001);
        push_a(0, 32'h100);
        a_ret = 1; tick; a_ret = 0;
        wait_req(0, n);
        a_take = 1; tick; a_take = 0;
        check("setwin_clr", a_pend, 4'b0000);
        a_ret = 1; tick; a_ret = 0;

        // level source withdraw via mask, then re-enable
        push_b(0, 32'h100);
        b_irq = 4'b0001;
        wait_req(1, n);
        check("lvl_pend", b_pend, 4'b0001);
        b_mwe = 1; b_mwd = 4'hE; tick; b_mwe = 0;
        check("lvl_mask", b_mask, 4'hE);
        tick;
        check("lvl_withdraw", b_req, 0);
        check("lvl_pend_unmasked", b_pend, 4'b0001);
        push_b(0, 32'h100);
        b_mwe = 1; b_mwd = 4'hF; tick; b_mwe = 0;
        wait_req(1, n);
        b_take = 1; tick; b_take = 0;
        check("lvl_svc", b_svc, 1);
        check("lvl_take_keep", b_pend, 4'b0001);
        b_irq = '0;
        repeat (3) tick;
        check("lvl_drop", b_pend, 4'b0000);
        b_ret = 1; tick; b_ret = 0;
        check("lvl_ret", b_svc, 0);
        tick;
        check("lvl_idle", b_req, 0);

        // reset in SERVICE with another edge pending
        push_a(1, 32'h110);
        a_irq = 4'b0010; tick; a_irq = '0;
        wait_req(0, n);
        a_take = 1; tick; a_take = 0;
        check("pre_rst_svc", a_svc, 1);
        a_irq = 4'b0100; tick; a_irq = '0;
        repeat (3) tick;
        check("pre_rst_pend", a_pend, 4'b0100);
        rst = 1; tick; rst = 0;
        check("post_rst_svc", a_svc, 0);
        check("post_rst_pend", a_pend, 4'b0000);
        check("post_rst_req", a_req, 0);
        check("post_rst_mask", a_mask, 4'h0);
        a_ret = 1; tick; a_ret = 0;
        tick;
        check("ret_ignored_svc", a_svc, 0);
        check("ret_ignored_req", a_req, 0);

        repeat (4) tick;
        check("exp_a_empty", exp_a.size(), 0);
        check("exp_b_empty", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
